// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI slave supporting all four CPOL/CPHA modes, with an RX
// FIFO and a TX holding register on valid/ready handshakes. SPI pins are
// oversampled in the clk domain. Each SCLK half-period must last at least
// SYNC_STAGES+3 clk cycles.
//
// Optional feature: define SPI_SLAVE_LSB_FIRST_EN to add the lsb_first input.
// lsb_first is latched at frame start. When it is 1, words are shifted LSB-first.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   sclk, mosi, cs_n         asynchronous SPI pins (synchronised internally)
//   miso                     SPI data out; 0 while no frame is active
//   cpol, cpha               SPI mode, latched at frame start
//   lsb_first                (macro only) bit order, latched at frame start
//   rx_data/valid/ready      RX FIFO head; pop on valid && ready
//   rx_level                 RX FIFO occupancy
//   tx_data/valid/ready      TX holding register write port
//   rx_overrun, tx_underrun  sticky error flags; err_clr clears both
//   busy                     frame active
//   frame_done               one-cycle pulse at frame end
module spi_slave_fifo #(
  parameter int WORD_W      = 8,
  parameter int RX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sclk,
  input  logic                        mosi,
  input  logic                        cs_n,
  output logic                        miso,
  input  logic                        cpol,
  input  logic                        cpha,
`ifdef SPI_SLAVE_LSB_FIRST_EN
  input  logic                        lsb_first,
`endif
  output logic [WORD_W-1:0]           rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  input  logic [WORD_W-1:0]           tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        rx_overrun,
  output logic                        tx_underrun,
  input  logic                        err_clr,
  output logic                        busy,
  output logic                        frame_done
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(RX_DEPTH);

  // Pin synchronisers (sclk and cs_n reset low so a frame already in
  // progress at reset release never produces a falling cs_n edge).
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    end
  end
  always_ff @(posedge clk) mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};

  logic sclk_s, cs_s, mosi_s;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Control state
  logic              sclk_prev_q, cs_prev_q, frame_q, frame_done_q;
  logic              cpol_q, cpha_q, pend_q, pend_d, wend_q, wend_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              hold_vld_q, hold_vld_d, ovr_q, ovr_d, unr_q, unr_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  // Datapath state
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, hold_q;
  logic [WORD_W-1:0] mem [RX_DEPTH];

  logic lsb_mode;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  logic lsb_q;
  always_ff @(posedge clk) begin
    if (rst)                        lsb_q <= 1'b0;
    else if (cs_prev_q && !cs_s)    lsb_q <= lsb_first;
  end
  assign lsb_mode = lsb_q;
`else
  assign lsb_mode = 1'b0;
`endif

  logic frame_start, frame_end, act, lead, trail, samp, shft;
  logic push, pop, full, wr_en, reload, accept;
  logic [WORD_W-1:0] reload_word;

  always_comb begin
    frame_start = cs_prev_q && !cs_s;
    frame_end   = frame_q && !cs_prev_q && cs_s;
    act         = frame_q && !cs_s;
    lead        = act && (sclk_prev_q == cpol_q) && (sclk_s != cpol_q);
    trail       = act && (sclk_prev_q != cpol_q) && (sclk_s == cpol_q);
    samp        = cpha_q ? trail : lead;
    shft        = cpha_q ? lead : trail;

    push   = samp && (bit_cnt_q == LAST_BIT);
    pop    = rx_ready && (count_q != '0);
    full   = (count_q == FULL_LVL);
    wr_en  = push && (!full || pop);
    accept = tx_valid && !hold_vld_q;
    // A word boundary reload only happens once the last bit has been sampled.
    reload = frame_start || (shft && pend_q && wend_q);
    reload_word = hold_vld_q ? hold_q : '0;

    rx_shift_d = rx_shift_q;
    if (samp)
      rx_shift_d = lsb_mode ? {mosi_s, rx_shift_q[WORD_W-1:1]}
                            : {rx_shift_q[WORD_W-2:0], mosi_s};

    tx_shift_d = tx_shift_q;
    if (reload)
      tx_shift_d = reload_word;
    else if (shft && pend_q)
      tx_shift_d = lsb_mode ? (tx_shift_q >> 1) : (tx_shift_q << 1);

    bit_cnt_d = bit_cnt_q;
    pend_d    = pend_q;
    wend_d    = wend_q;
    if (frame_start || frame_end) begin
      bit_cnt_d = '0;
      pend_d    = 1'b0;
      wend_d    = 1'b0;
    end else if (samp) begin
      bit_cnt_d = push ? '0 : bit_cnt_q + 1'b1;
      pend_d    = 1'b1;
      if (push) wend_d = 1'b1;
    end else if (shft && pend_q) begin
      pend_d = 1'b0;
      wend_d = 1'b0;
    end

    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;

    hold_vld_d = accept || (hold_vld_q && !reload);
    ovr_d      = (push && full && !pop) || (ovr_q && !err_clr);
    unr_d      = (reload && !hold_vld_q) || (unr_q && !err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b0;
      frame_q      <= 1'b0;
      frame_done_q <= 1'b0;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      bit_cnt_q    <= '0;
      pend_q       <= 1'b0;
      wend_q       <= 1'b0;
      hold_vld_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovr_q        <= 1'b0;
      unr_q        <= 1'b0;
    end else begin
      sclk_prev_q  <= sclk_s;
      cs_prev_q    <= cs_s;
      frame_done_q <= frame_end;
      if (frame_start) begin
        frame_q <= 1'b1;
        cpol_q  <= cpol;
        cpha_q  <= cpha;
      end else if (frame_end) begin
        frame_q <= 1'b0;
      end
      bit_cnt_q  <= bit_cnt_d;
      pend_q     <= pend_d;
      wend_q     <= wend_d;
      hold_vld_q <= hold_vld_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      unr_q      <= unr_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    tx_shift_q <= tx_shift_d;
    if (accept) hold_q <= tx_data;
    // When full, wr_ptr equals rd_ptr; the popped head is read this cycle
    // before the incoming word overwrites that slot.
    if (wr_en) mem[wr_ptr_q] <= rx_shift_d;
  end

  assign rx_valid    = (count_q != '0);
  assign rx_data     = rx_valid ? mem[rd_ptr_q] : '0;
  assign rx_level    = count_q;
  assign tx_ready    = !hold_vld_q;
  assign rx_overrun  = ovr_q;
  assign tx_underrun = unr_q;
  assign busy        = frame_q;
  assign frame_done  = frame_done_q;
  assign miso        = frame_q ? (lsb_mode ? tx_shift_q[0] : tx_shift_q[WORD_W-1]) : 1'b0;

endmodule

// File: tb/tb_spi_slave_fifo.sv
module tb_spi_slave_fifo;
  localparam int HP = 8;  // SCLK half-period in clk cycles

  logic       clk, rst, sclk, mosi, cs_n, cpol, cpha, rx_ready, tx_valid, err_clr;
  logic [7:0] tx_data;
  logic       miso, rx_valid, tx_ready, rx_overrun, tx_underrun, busy, frame_done;
  logic [7:0] rx_data;
  logic [2:0] rx_level;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  spi_slave_fifo #(.WORD_W(8), .RX_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLAVE_LSB_FIRST_EN
    .lsb_first(1'b0),
`endif
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_level(rx_level),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .err_clr(err_clr),
    .busy(busy), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic half();
    repeat (HP) @(negedge clk);
  endtask

  task automatic start_frame(input logic pol, input logic pha);
    cpol = pol; cpha = pha; sclk = pol;
    half();
    cs_n = 1'b0;
    half();
  endtask

  task automatic end_frame();
    half();
    cs_n = 1'b1;
    half();
  endtask

  task automatic send_tx(input logic [7:0] w);
    bit done = 0;
    tx_data = w; tx_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (tx_ready === 1'b0) done = 1;
    end
    tx_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL tx_accept: tx_ready stayed %b, required 0 after offer of %h", tx_ready, w);
    end
  endtask

  task automatic pop_word(output logic [7:0] w, output logic v);
    w = rx_data; v = rx_valid;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  // Master side of one word, MSB-first, nbits bits. With pop_last set,
  // rx_ready is pulsed for the single clk cycle in which the slave pushes the
  // completed word (2 synchroniser flops + 1 edge-history flop after SCLK).
  task automatic xfer(input logic [7:0] tx, input int nbits, input bit pop_last,
                      output logic [7:0] rx, output logic [7:0] popped);
    rx = '0; popped = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = tx[i]; half();
        rx[i] = miso; sclk = ~cpol;
        if (pop_last && i == 0) begin
          @(negedge clk); @(negedge clk);
          popped = rx_data; rx_ready = 1'b1;
          @(negedge clk);
          rx_ready = 1'b0;
          repeat (HP - 3) @(negedge clk);
        end else begin
          half();
        end
        sclk = cpol;
      end else begin
        sclk = ~cpol; mosi = tx[i]; half();
        rx[i] = miso; sclk = cpol; half();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL reset_rx_level: got %0d required 0", rx_level); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b required 0", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b required 0", frame_done); end
    checks++; if ({rx_overrun, tx_underrun} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b required 00", {rx_overrun, tx_underrun}); end
    rst = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic test_mode0();
    logic [7:0] r, p, w; logic v; int fd0;
    fd0 = fd_cnt;
    send_tx(8'h3C);
    start_frame(1'b0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL m0_busy: got %b required 1", busy); end
    xfer(8'hA5, 8, 0, r, p);
    end_frame();
    checks++; if (r !== 8'h3C) begin errors++; $display("FAIL m0_miso_word: got %h required 3c", r); end
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin errors++; $display("FAIL m0_rx: got valid=%b data=%h required 1/a5", rx_valid, rx_data); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL m0_tx_ready: got %b required 1", tx_ready); end
    // The word-end reload on the last shift edge finds the holding register empty.
    checks++; if (tx_underrun !== 1'b1) begin errors++; $display("FAIL m0_end_underrun: got %b required 1", tx_underrun); end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL m0_frame_done: got %0d pulses required 1", fd_cnt - fd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL m0_busy_end: got %b required 0", busy); end
    pop_word(w, v);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL m0_pop_empty: got valid=%b required 0", rx_valid); end
    pulse_err_clr();
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL m0_err_clr: got %b required 0", tx_underrun); end
  endtask

  task automatic test_mode3_back_to_back();
    logic [7:0] r1, r2, p, w; logic v;
    send_tx(8'hC3);
    start_frame(1'b1, 1'b1);
    send_tx(8'h5A);
    xfer(8'h12, 8, 0, r1, p);
    xfer(8'h34, 8, 0, r2, p);
    end_frame();
    checks++; if (r1 !== 8'hC3) begin errors++; $display("FAIL m3_miso_w1: got %h required c3", r1); end
    checks++; if (r2 !== 8'h5A) begin errors++; $display("FAIL m3_miso_w2: got %h required 5a", r2); end
    checks++; if (rx_level !== 3'd2) begin errors++; $display("FAIL m3_level: got %0d required 2", rx_level); end
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL m3_underrun: got %b required 0", tx_underrun); end
    pop_word(w, v);
    checks++; if (w !== 8'h12 || v !== 1'b1) begin errors++; $display("FAIL m3_pop1: got %h/%b required 12/1", w, v); end
    pop_word(w, v);
    checks++; if (w !== 8'h34 || v !== 1'b1) begin errors++; $display("FAIL m3_pop2: got %h/%b required 34/1", w, v); end
  endtask

  task automatic test_overrun();
    logic [7:0] r, p, w; logic v;
    logic [7:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    start_frame(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) xfer(words[k], 8, 0, r, p);
    end_frame();
    checks++; if (rx_level !== 3'd4) begin errors++; $display("FAIL ovr_level: got %0d required 4", rx_level); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b required 1", rx_overrun); end
    for (int k = 0; k < 4; k++) begin
      pop_word(w, v);
      checks++; if (w !== words[k] || v !== 1'b1) begin errors++; $display("FAIL ovr_drain%0d: got %h/%b required %h/1", k, w, v, words[k]); end
    end
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL ovr_empty: got %b/%h required 0/00", rx_valid, rx_data); end
    pulse_err_clr();
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b required 0", rx_overrun); end
  endtask

  task automatic test_underrun();
    logic [7:0] r, p, w; logic v;
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL unr_pre_ready: got %b required 1", tx_ready); end
    start_frame(1'b0, 1'b0);
    xfer(8'h5A, 8, 0, r, p);
    end_frame();
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL unr_miso: got %h required 00", r); end
    checks++; if (tx_underrun !== 1'b1) begin errors++; $display("FAIL unr_flag: got %b required 1", tx_underrun); end
    pop_word(w, v);
    checks++; if (w !== 8'h5A) begin errors++; $display("FAIL unr_rx: got %h required 5a", w); end
    pulse_err_clr();
  endtask

  task automatic test_abort();
    logic [7:0] r, p, w; logic v; int fd0;
    fd0 = fd_cnt;
    start_frame(1'b0, 1'b0);
    xfer(8'hFF, 5, 0, r, p);
    end_frame();
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL abort_no_push: got level %0d required 0", rx_level); end
    checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL abort_fd1: got %0d pulses required 1", fd_cnt - fd0); end
    start_frame(1'b0, 1'b0);
    xfer(8'h81, 8, 0, r, p);
    end_frame();
    checks++; if (rx_level !== 3'd1 || rx_data !== 8'h81) begin errors++; $display("FAIL abort_next: got %0d/%h required 1/81", rx_level, rx_data); end
    checks++; if (fd_cnt - fd0 !== 2) begin errors++; $display("FAIL abort_fd2: got %0d pulses required 2", fd_cnt - fd0); end
    pop_word(w, v);
    pulse_err_clr();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] r, p, w; logic v;
    start_frame(1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) xfer(8'(k), 8, 0, r, p);
    xfer(8'h05, 8, 1, r, p);
    end_frame();
    checks++; if (p !== 8'h01) begin errors++; $display("FAIL fpp_popped: got %h required 01", p); end
    checks++; if (rx_level !== 3'd4) begin errors++; $display("FAIL fpp_level: got %0d required 4", rx_level); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL fpp_overrun: got %b required 0", rx_overrun); end
    for (int k = 2; k <= 5; k++) begin
      pop_word(w, v);
      checks++; if (w !== 8'(k)) begin errors++; $display("FAIL fpp_drain%0d: got %h required %h", k, w, 8'(k)); end
    end
    pulse_err_clr();
  endtask

  task automatic test_rst_midframe();
    logic [7:0] r, p;
    start_frame(1'b0, 1'b0);
    xfer(8'hF0, 3, 0, r, p);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    xfer(8'hC3, 8, 0, r, p);
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL rstmid_ignored: got level %0d required 0", rx_level); end
    end_frame();
    start_frame(1'b0, 1'b0);
    xfer(8'h66, 8, 0, r, p);
    end_frame();
    checks++; if (rx_level !== 3'd1 || rx_data !== 8'h66) begin errors++; $display("FAIL rstmid_recover: got %0d/%h required 1/66", rx_level, rx_data); end
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; cpol = 1'b0; cpha = 1'b0;
    rx_ready = 1'b0; tx_valid = 1'b0; tx_data = '0; err_clr = 1'b0;
    test_reset();
    test_mode0();
    test_mode3_back_to_back();
    test_overrun();
    test_underrun();
    test_abort();
    test_full_push_pop();
    test_rst_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
